adc_responder: RTL and testbench



---
 rtl/adc_pkg.sv | 19 +
 rtl/sar_core.sv | 78 +++++++
 rtl/adc_responder.sv | 82 ++++++++
 tb/tb_adc_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC stand-in and its controller:
// the state encoding, the default width and the conversion latency.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } adc_state_e;

  localparam int DATA_W_DEFAULT = 8;

  // Clocks from the edge where start is first sampled low until eoc rises.
  function automatic int conv_latency(input int data_w, input int step_cycles);
    return data_w * step_cycles + 1;
  endfunction

endpackage

// File: rtl/sar_core.sv
// Successive-approximation search: trial register, bit index and step counter.
// last_bit goes high once the LSB has been decided and holds until reloaded.
module sar_core #(
  parameter int DATA_W      = 8,
  parameter int STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              advance,
  input  logic [DATA_W-1:0] vin_hold,
  output logic [DATA_W-1:0] sar,
  output logic              last_bit
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [DATA_W-1:0] sar_q, sar_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] cur_bit;
  logic [DATA_W-1:0] decided;

  always_comb begin
    sar_d   = sar_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_bit = DATA_W'(1) << idx_q;
    // Trial bit survives only if the trial value does not exceed the input.
    decided = (sar_q <= vin_hold) ? sar_q : (sar_q & ~cur_bit);
    if (clr) begin
      sar_d  = '0;
      idx_d  = IW'(DATA_W - 1);
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (load) begin
      sar_d  = DATA_W'(1) << (DATA_W - 1);
      idx_d  = IW'(DATA_W - 1);
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (advance && !last_q) begin
      if (cnt_q == CW'(STEP_CYCLES - 1)) begin
        cnt_d = '0;
        if (idx_q == '0) begin
          sar_d  = decided;
          last_d = 1'b1;
        end else begin
          sar_d = decided | (cur_bit >> 1);
          idx_d = idx_q - 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sar_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      sar_q  <= sar_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign sar      = sar_q;
  assign last_bit = last_q;

endmodule

// File: rtl/adc_responder.sv
// Cycle-accurate stand-in for an 8-bit SAR ADC answering start/eoc/oe.
// start rising arms, start falling launches; data is gated combinationally by oe.
module adc_responder
  import adc_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int STEP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              oe,
  input  logic [DATA_W-1:0] vin,
  output logic              eoc,
  output logic [DATA_W-1:0] data,
  output logic              data_en,
  output logic              busy
);

  adc_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] vin_hold_q;
  logic [DATA_W-1:0] sar;
  logic              last_bit;
  logic              clr, load, advance, capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = ARMED;
      ARMED:      state_d = start ? ARMED : CONVERT;
      CONVERT: begin
        if (start)         state_d = ARMED;
        else if (last_bit) state_d = DONE;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    eoc     = (state_q == IDLE) || (state_q == DONE);
    busy    = (state_q == ARMED) || (state_q == CONVERT);
    clr     = (state_d == ARMED);
    load    = (state_q == ARMED) && !start;
    advance = (state_q == CONVERT) && !start && !last_bit;
    capture = (state_q == CONVERT) && !start && last_bit;
  end

  // result only changes when a conversion finishes, so aborts leave it intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      vin_hold_q <= '0;
    end else begin
      if (load)    vin_hold_q <= vin;
      if (capture) result_q   <= sar;
    end
  end

  sar_core #(
    .DATA_W      (DATA_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_sar_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .load     (load),
    .advance  (advance),
    .vin_hold (vin_hold_q),
    .sar      (sar),
    .last_bit (last_bit)
  );

  assign data    = oe ? result_q : '0;
  assign data_en = oe;

endmodule

// File: tb/tb_adc_responder.sv
// Randomised self-checking bench for adc_responder; the reference model is
// "result = vin at launch, eoc after conv_latency clocks".
module tb_adc_responder;
  import adc_pkg::*;

  localparam int DW  = 8;
  localparam int SC  = 4;
  localparam int LAT = conv_latency(DW, SC);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          oe = 1'b0;
  logic [DW-1:0] vin = '0;
  logic          eoc;
  logic [DW-1:0] data;
  logic          data_en;
  logic          busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_result = '0;

  adc_responder #(.DATA_W(DW), .STEP_CYCLES(SC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .oe      (oe),
    .vin     (vin),
    .eoc     (eoc),
    .data    (data),
    .data_en (data_en),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Arms with a one-cycle start pulse and returns at the launch edge.
  task automatic arm_launch(input logic [DW-1:0] v, output logic eoc_armed,
                            output logic busy_armed);
    @(posedge clk); #1;
    vin = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    eoc_armed  = eoc;
    busy_armed = busy;
    @(posedge clk);
  endtask

  // Counts clocks until eoc is seen high, bounded so a stuck DUT cannot hang.
  task automatic wait_eoc(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (eoc) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    oe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (eoc !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags eoc=%b busy=%b required eoc=1 busy=0", eoc, busy);
    end
    tests_run++;
    if (data !== '0 || data_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_data data=%h en=%b required data=00 en=1", data, data_en);
    end
    oe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_result = '0;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    logic ea, ba;
    int lat;
    arm_launch(8'hA5, ea, ba);
    tests_run++;
    if (ea !== 1'b0 || ba !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_armed eoc=%b busy=%b required eoc=0 busy=1", ea, ba);
    end
    wait_eoc(lat);
    exp_result = 8'hA5;
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL basic_latency got=%0d required=%0d", lat, LAT);
    end
    @(posedge clk); #1;
    oe = 1'b1;
    #1;
    tests_run++;
    if (data !== exp_result || data_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_read data=%h en=%b required data=%h en=1", data, data_en, exp_result);
    end
    @(posedge clk); #1;
    oe = 1'b0;
    #1;
    tests_run++;
    if (data !== '0 || data_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_oe_off data=%h en=%b required data=00 en=0", data, data_en);
    end
    $display("[TB] basic vin=A5 latency=%0d", lat);
  endtask

  task automatic test_back_to_back();
    logic ea, ba;
    int lat;
    logic [DW-1:0] vals [2];
    vals[0] = 8'h00;
    vals[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      arm_launch(vals[i], ea, ba);
      wait_eoc(lat);
      exp_result = vals[i];
      tests_run++;
      if (data !== '0) begin
        tests_failed++;
        $display("FAIL b2b_gated data=%h required=00", data);
      end
      oe = 1'b1;
      #1;
      tests_run++;
      if (data !== exp_result || lat !== LAT) begin
        tests_failed++;
        $display("FAIL b2b_result data=%h lat=%0d required data=%h lat=%0d", data, lat, exp_result, LAT);
      end
      oe = 1'b0;
      $display("[TB] back_to_back vin=%h data=%h", vals[i], exp_result);
    end
  endtask

  task automatic test_vin_change();
    logic ea, ba;
    int lat;
    arm_launch(8'h3C, ea, ba);
    repeat (5) @(posedge clk);
    #1 vin = 8'hC3;
    wait_eoc(lat);
    exp_result = 8'h3C;
    oe = 1'b1;
    #1;
    tests_run++;
    if (data !== exp_result || lat + 5 !== LAT) begin
      tests_failed++;
      $display("FAIL vin_hold data=%h lat=%0d required data=%h lat=%0d", data, lat + 5, exp_result, LAT);
    end
    oe = 1'b0;
    $display("[TB] vin_change held=3C");
  endtask

  task automatic test_oe_mid_convert();
    logic ea, ba;
    int lat;
    arm_launch(8'h11, ea, ba);
    wait_eoc(lat);
    exp_result = 8'h11;
    arm_launch(8'h7E, ea, ba);
    repeat (10) @(posedge clk);
    #1 oe = 1'b1;
    #1;
    tests_run++;
    if (data !== 8'h11 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL oe_mid_old data=%h busy=%b required data=11 busy=1", data, busy);
    end
    wait_eoc(lat);
    exp_result = 8'h7E;
    tests_run++;
    if (data !== exp_result || lat + 10 !== LAT) begin
      tests_failed++;
      $display("FAIL oe_mid_new data=%h lat=%0d required data=%h lat=%0d", data, lat + 10, exp_result, LAT);
    end
    oe = 1'b0;
    $display("[TB] oe_mid_convert old=11 new=7E");
  endtask

  task automatic test_abort();
    logic ea, ba;
    int lat;
    arm_launch(8'h55, ea, ba);
    repeat (10) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (eoc !== 1'b0 || busy !== 1'b1 || dut.result_q !== exp_result) begin
      tests_failed++;
      $display("FAIL abort_armed eoc=%b busy=%b required eoc=0 busy=1 result kept", eoc, busy);
    end
    @(posedge clk);
    wait_eoc(lat);
    exp_result = 8'h55;
    oe = 1'b1;
    #1;
    tests_run++;
    if (data !== exp_result || lat !== LAT) begin
      tests_failed++;
      $display("FAIL abort_restart data=%h lat=%0d required data=%h lat=%0d", data, lat, exp_result, LAT);
    end
    oe = 1'b0;
    $display("[TB] abort restart vin=55 latency=%0d", lat);
  endtask

  task automatic test_async_reset();
    logic ea, ba;
    int lat;
    arm_launch(8'h9A, ea, ba);
    repeat (7) @(posedge clk);
    #3;
    oe = 1'b1;
    reset = 1'b1;
    #1;
    exp_result = '0;
    tests_run++;
    if (eoc !== 1'b1 || busy !== 1'b0 || data !== exp_result) begin
      tests_failed++;
      $display("FAIL async_reset eoc=%b busy=%b data=%h required eoc=1 busy=0 data=00", eoc, busy, data);
    end
    oe = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    arm_launch(8'h6B, ea, ba);
    wait_eoc(lat);
    exp_result = 8'h6B;
    oe = 1'b1;
    #1;
    tests_run++;
    if (data !== exp_result || lat !== LAT) begin
      tests_failed++;
      $display("FAIL post_reset_conv data=%h lat=%0d required data=%h lat=%0d", data, lat, exp_result, LAT);
    end
    oe = 1'b0;
    $display("[TB] async_reset then vin=6B");
  endtask

  task automatic test_random();
    logic ea, ba;
    int lat, k;
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = DW'($urandom);
      k = $urandom_range(1, 20);
      arm_launch(v, ea, ba);
      repeat (k) @(posedge clk);
      #1 vin = DW'($urandom);
      wait_eoc(lat);
      exp_result = v;
      @(posedge clk); #1;
      oe = 1'b1;
      #1;
      tests_run++;
      if (data !== exp_result || lat + k !== LAT || ea !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_conv data=%h lat=%0d eoc_armed=%b required data=%h lat=%0d eoc_armed=0",
                 data, lat + k, ea, exp_result, LAT);
      end
      @(posedge clk); #1;
      oe = 1'b0;
      $display("[TB] random vin=%h data=%h", v, exp_result);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_vin_change();
    test_oe_mid_convert();
    test_abort();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
